// File: rtl/ssd_display_arbiter.sv
// Round-robin arbiter that shares the two-digit seven-segment display among four requesters.
// Grants are held for a minimum dwell time, channel 0 can preempt, and each channel can blink.
module ssd_display_arbiter #(
   parameter int DWELL_CYCLES = 50000000,
   parameter int BLINK_HALF   = 12500000,
   parameter bit PREEMPT_CH0  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [31:0] req_value,
   input  logic [3:0]  blink_en,
   output logic [3:0]  gnt,
   output logic [7:0]  disp_value,
   output logic        disp_blank,
   output logic        busy
);
   localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t        state_q, state_d;
   logic [1:0]    cur_q, cur_d;
   logic [1:0]    rr_ptr_q, rr_ptr_d;
   logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_phase_q, blink_phase_d;
   logic [3:0]    gnt_q, gnt_d;
   logic [7:0]    disp_value_q, disp_value_d;
   logic          disp_blank_q, disp_blank_d;
   logic          grant_new;
   logic [3:0]    others;

   // First requesting channel found searching upward from ptr, modulo 4.
   function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] mask);
      logic [1:0] idx;
      rr_pick = ptr;
      for (int i = 3; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (mask[idx]) rr_pick = idx;
      end
   endfunction

   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves it unassigned, which would infer a latch.
      state_d       = state_q;
      cur_d         = cur_q;
      rr_ptr_d      = rr_ptr_q;
      dwell_cnt_d   = dwell_cnt_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      disp_value_d  = disp_value_q;
      disp_blank_d  = disp_blank_q;
      grant_new     = 1'b0;
      others        = req & ~(4'b0001 << cur_q);

      unique case (state_q)
         IDLE: begin
            if (|req) begin
               cur_d     = rr_pick(rr_ptr_q, req);
               grant_new = 1'b1;
            end
         end
         HOLD: begin
            if (PREEMPT_CH0 && (cur_q != 2'd0) && req[0]) begin
               cur_d     = 2'd0;
               grant_new = 1'b1;
            end else if (!req[cur_q]) begin
               if (|req) begin
                  cur_d     = rr_pick(rr_ptr_q, req);
                  grant_new = 1'b1;
               end else begin
                  state_d     = IDLE;
                  dwell_cnt_d = '0;
               end
            end else if (!(PREEMPT_CH0 && (cur_q == 2'd0)) &&
                         (dwell_cnt_q == DWELL_LAST) && (|others)) begin
               cur_d     = rr_pick(rr_ptr_q, others);
               grant_new = 1'b1;
            end else if (dwell_cnt_q != DWELL_LAST) begin
               dwell_cnt_d = dwell_cnt_q + DW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (grant_new) begin
         state_d     = HOLD;
         rr_ptr_d    = cur_d + 2'd1;
         dwell_cnt_d = '0;
      end

      // Blink restarts visible on every new grant; the display is dark while idle.
      if (grant_new || (state_d == IDLE)) begin
         blink_cnt_d   = '0;
         blink_phase_d = 1'b0;
         disp_blank_d  = (state_d == IDLE);
      end else if (blink_en[cur_d]) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
         end
         disp_blank_d = blink_phase_d;
      end else begin
         blink_cnt_d   = '0;
         blink_phase_d = 1'b0;
         disp_blank_d  = 1'b0;
      end

      if (state_d == HOLD) disp_value_d = req_value[{cur_d, 3'b000} +: 8];
      gnt_d = (state_d == HOLD) ? (4'b0001 << cur_d) : 4'b0000;
   end

   // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         cur_q         <= 2'd0;
         rr_ptr_q      <= 2'd0;
         dwell_cnt_q   <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         gnt_q         <= 4'b0000;
         disp_value_q  <= 8'h00;
         disp_blank_q  <= 1'b1;
      end else begin
         state_q       <= state_d;
         cur_q         <= cur_d;
         rr_ptr_q      <= rr_ptr_d;
         dwell_cnt_q   <= dwell_cnt_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         gnt_q         <= gnt_d;
         disp_value_q  <= disp_value_d;
         disp_blank_q  <= disp_blank_d;
      end
   end

   assign gnt        = gnt_q;
   assign disp_value = disp_value_q;
   assign disp_blank = disp_blank_q;
   assign busy       = |gnt_q;
endmodule
